// File: rtl/regs_pkg.sv
// regs_pkg: shared controller states and default sizing for the regs_mem_mp register file.
package regs_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int REGS_WIDTH = 8;
  localparam int REGS_DEPTH = 16;
  localparam int REGS_UNITY = 1 << 4;
endpackage

// File: rtl/regs_init_seq.sv
// regs_init_seq: INIT/RUN controller that sweeps every address once after reset, then raises ready.
module regs_init_seq
  import regs_pkg::*;
#(
  parameter int DEPTH  = REGS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, last;
  always_comb begin
    last  = cnt_q == ADDR_W'(DEPTH - 1);
    cnt_d = last ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      state_q <= last ? RUN : INIT;
      cnt_q   <= cnt_d;
      ready_q <= last;
    end
  end
  assign init_we   = state_q == INIT && !rst;
  assign init_addr = cnt_q;
  assign ready     = ready_q;
endmodule

// File: rtl/regs_mem_mp.sv
// regs_mem_mp: 1-write/2-read register file with init sweep, optional zero register and write bypass.
module regs_mem_mp
  import regs_pkg::*;
#(
  parameter int WIDTH    = REGS_WIDTH,
  parameter int DEPTH    = REGS_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INIT_VAL = REGS_UNITY,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  qa,
  output logic [WIDTH-1:0]  qb,
  output logic              ready
);
  logic              init_we, run_we, wen;
  logic [ADDR_W-1:0] init_addr, waddr;
  logic [WIDTH-1:0]  wdata, qa_d, qb_d, qa_q, qb_q;
  logic [WIDTH-1:0]  mem [DEPTH];
  regs_init_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .init_we  (init_we),
    .init_addr(init_addr),
    .ready    (ready)
  );
  // Sweep owns the write port until ready; reads of a hardwired zero register win over bypass.
  always_comb begin
    run_we = ready && we && !rst;
    wen    = init_we || (run_we && !(ZERO_REG != 0 && wr_addr == '0));
    waddr  = init_we ? init_addr : wr_addr;
    wdata  = init_we ? ((ZERO_REG != 0 && init_addr == '0) ? '0 : WIDTH'(INIT_VAL)) : d;
    qa_d   = (ZERO_REG != 0 && rd_addr_a == '0) ? '0 :
             (BYPASS != 0 && run_we && wr_addr == rd_addr_a) ? d : mem[rd_addr_a];
    qb_d   = (ZERO_REG != 0 && rd_addr_b == '0) ? '0 :
             (BYPASS != 0 && run_we && wr_addr == rd_addr_b) ? d : mem[rd_addr_b];
  end
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    qa_q <= (rst || !ready) ? '0 : qa_d;
    qb_q <= (rst || !ready) ? '0 : qb_d;
  end
  assign qa = qa_q;
  assign qb = qb_q;
endmodule

// File: tb/tb_regs_mem_mp.sv
// tb_regs_mem_mp: directed + random checks of two regs_mem_mp builds (default, and no-bypass/no-zero-reg).
module tb_regs_mem_mp;
  localparam int N = 16;
  localparam logic [7:0] IV = 8'd16;
  logic       clk = 1'b0, rst = 1'b1, we = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [7:0] d = '0;
  logic [7:0] qa, qb, qa0, qb0;
  logic       ready, ready0;
  always #5 clk = ~clk;
  regs_mem_mp dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d(d),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .qa(qa), .qb(qb), .ready(ready)
  );
  regs_mem_mp #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d(d),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .qa(qa0), .qb(qb0), .ready(ready0)
  );
  typedef struct packed {
    logic [7:0] qa, qb, qa0, qb0;
    logic       rdy;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] m1 [N];
  logic [7:0] m0 [N];
  logic       rdy_m = 1'b0;
  int         cnt_m = 0;
  int         checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic r, input logic w, input logic [3:0] wa, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [7:0] dv, input string tag);
    exp_t e;
    rst = r; we = w; wr_addr = wa; rd_addr_a = ra; rd_addr_b = rb; d = dv;
    e = '0;
    if (r) begin
      rdy_m = 1'b0;
      cnt_m = 0;
    end else if (!rdy_m) begin
      m1[cnt_m] = (cnt_m == 0) ? 8'h00 : IV;
      m0[cnt_m] = IV;
      if (cnt_m == N - 1) rdy_m = 1'b1;
      else cnt_m++;
      e.rdy = rdy_m;
    end else begin
      e.rdy = 1'b1;
      e.qa  = (ra == 0) ? 8'h00 : (w && wa == ra) ? dv : m1[ra];
      e.qb  = (rb == 0) ? 8'h00 : (w && wa == rb) ? dv : m1[rb];
      e.qa0 = m0[ra];
      e.qb0 = m0[rb];
      if (w && wa != 0) m1[wa] = dv;
      if (w) m0[wa] = dv;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".qa"}, qa, e.qa);
    chk({tag, ".qb"}, qb, e.qb);
    chk({tag, ".qa0"}, qa0, e.qa0);
    chk({tag, ".qb0"}, qb0, e.qb0);
    chk({tag, ".ready"}, {7'b0, ready}, {7'b0, e.rdy});
    chk({tag, ".ready0"}, {7'b0, ready0}, {7'b0, e.rdy});
  endtask
  initial begin
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, "rst");
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 4'(i), 4'(i), 8'h55, "sweep");
      if (i == N - 2) chk("sweep.ready_low", {7'b0, ready}, 8'd0);
      if (i == N - 1) chk("sweep.ready_high", {7'b0, ready}, 8'd1);
    end
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 4'(i), 4'(N - 1 - i), 8'h00, "init_rd");
      chk("init_rd.const", qa, (i == 0) ? 8'h00 : IV);
      chk("init_rd.const0", qa0, IV);
    end
    cycle(1'b0, 1'b1, 4'd3, 4'd1, 4'd2, 8'hA5, "wr3");
    cycle(1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 8'h00, "rd3");
    chk("rd3.const_a", qa, 8'hA5);
    chk("rd3.const_b", qb, 8'hA5);
    cycle(1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 8'h3C, "byp");
    chk("byp.const", qa, 8'h3C);
    chk("byp.const_nb", qa0, IV);
    cycle(1'b0, 1'b0, 4'd0, 4'd5, 4'd5, 8'h00, "byp_rd");
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 8'hFF, "z_wr");
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 8'h00, "z_rd");
    chk("z_rd.const", qa, 8'h00);
    chk("z_rd.const0", qa0, 8'hFF);
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 1'($urandom_range(1, 0)), 4'($urandom_range(N - 1, 0)), 4'($urandom_range(N - 1, 0)),
            4'($urandom_range(N - 1, 0)), 8'($urandom_range(255, 0)), "rand");
    cycle(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 8'h77, "run_rst");
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, "part_sweep");
    cycle(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 8'h77, "mid_rst");
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, "resweep");
      if (i == N - 2) chk("resweep.ready_low", {7'b0, ready}, 8'd0);
      if (i == N - 1) chk("resweep.ready_high", {7'b0, ready}, 8'd1);
    end
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 4'd0, 4'(i), 4'(N - 1 - i), 8'h00, "reinit_rd");
    cycle(1'b0, 1'b0, 4'd0, 4'd9, 4'd3, 8'h00, "discard");
    chk("discard.const", qa, IV);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'(i), 4'd1, 4'd2, 8'h99, "hold_rst");
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, "final_sweep");
    cycle(1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 8'h00, "final_rd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
